// File: rtl/ring_code_checker.sv
// Receive-side checker for a one-hot ring code: decodes the sampled position,
// verifies single-step advance, tracks lock, and counts laps and locked errors.
module ring_code_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LAP_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           ring_in,
  output logic                       out_valid,
  output logic [$clog2(WIDTH)-1:0]   idx,
  output logic                       locked,
  output logic                       err_illegal,
  output logic                       err_seq,
  output logic                       lap_pulse,
  output logic [LAP_W-1:0]           lap_count,
  output logic [7:0]                 err_count
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned GC_W  = $clog2(LOCK_CNT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic [GC_W-1:0]  GOOD_LAST = GC_W'(LOCK_CNT - 1);

  localparam logic [0:0] S_HUNT   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]       r_state;
  logic [GC_W-1:0]  r_good_cnt;
  logic [IDX_W-1:0] r_prev;
  logic             r_have_prev;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_idx;
  logic             r_err_illegal;
  logic             r_err_seq;
  logic             r_lap_pulse;
  logic [LAP_W-1:0] r_lap_count;
  logic [7:0]       r_err_count;

  logic [CNT_W-1:0] w_ones;
  logic [IDX_W-1:0] w_pos;
  logic [IDX_W-1:0] w_next;
  logic             w_legal;
  logic             w_step_ok;

  always_comb begin
    w_ones = '0;
    w_pos  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) begin
        w_ones = w_ones + CNT_W'(1);
        w_pos  = IDX_W'(i);
      end
    end
  end

  assign w_legal   = (w_ones == CNT_W'(1));
  assign w_next    = (r_prev == IDX_LAST) ? '0 : r_prev + IDX_W'(1);
  assign w_step_ok = w_legal && r_have_prev && (w_pos == w_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_HUNT;
      r_good_cnt    <= '0;
      r_prev        <= '0;
      r_have_prev   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_idx         <= '0;
      r_err_illegal <= 1'b0;
      r_err_seq     <= 1'b0;
      r_lap_pulse   <= 1'b0;
      r_lap_count   <= '0;
      r_err_count   <= '0;
    end else begin
      r_out_valid   <= 1'b0;
      r_err_illegal <= 1'b0;
      r_err_seq     <= 1'b0;
      r_lap_pulse   <= 1'b0;
      if (in_valid) begin
        if (w_legal) begin
          r_out_valid <= 1'b1;
          r_idx       <= w_pos;
          r_prev      <= w_pos;
          r_have_prev <= 1'b1;
        end else begin
          r_have_prev <= 1'b0;
        end

        if (r_state == S_HUNT) begin
          // First legal sample after a gap only seeds prev; it earns no credit.
          if (w_step_ok) begin
            if (r_good_cnt == GOOD_LAST) begin
              r_state    <= S_LOCKED;
              r_good_cnt <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + GC_W'(1);
            end
          end else begin
            r_good_cnt <= '0;
          end
        end else begin
          if (!w_step_ok) begin
            r_err_illegal <= !w_legal;
            r_err_seq     <= w_legal;
            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            r_state    <= S_HUNT;
            r_good_cnt <= '0;
          end else if (r_prev == IDX_LAST) begin
            r_lap_pulse <= 1'b1;
            r_lap_count <= r_lap_count + LAP_W'(1);
          end
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign idx         = r_idx;
  assign locked      = (r_state == S_LOCKED);
  assign err_illegal = r_err_illegal;
  assign err_seq     = r_err_seq;
  assign lap_pulse   = r_lap_pulse;
  assign lap_count   = r_lap_count;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_ring_code_checker.sv
// Directed bench for ring_code_checker (WIDTH=4, LOCK_CNT=3, LAP_W=8).
module tb_ring_code_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] ring_in;
  logic       out_valid;
  logic [1:0] idx;
  logic       locked;
  logic       err_illegal;
  logic       err_seq;
  logic       lap_pulse;
  logic [7:0] lap_count;
  logic [7:0] err_count;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  ring_code_checker #(.WIDTH(4), .LOCK_CNT(3), .LAP_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in),
    .out_valid(out_valid), .idx(idx), .locked(locked),
    .err_illegal(err_illegal), .err_seq(err_seq), .lap_pulse(lap_pulse),
    .lap_count(lap_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, input logic v, input logic [3:0] code);
    rst = r; in_valid = v; ring_in = code;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic expect_all(input string tag, input logic ov, input logic [1:0] ix,
                            input logic lk, input logic ei, input logic es,
                            input logic lp, input logic [7:0] lc, input logic [7:0] ec);
    chk({tag, ".out_valid"},   out_valid,   ov);
    chk({tag, ".idx"},         idx,         ix);
    chk({tag, ".locked"},      locked,      lk);
    chk({tag, ".err_illegal"}, err_illegal, ei);
    chk({tag, ".err_seq"},     err_seq,     es);
    chk({tag, ".lap_pulse"},   lap_pulse,   lp);
    chk({tag, ".lap_count"},   lap_count,   lc);
    chk({tag, ".err_count"},   err_count,   ec);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; ring_in = '0;
    @(negedge clk);

    // 1: reset then acquisition; the 3->0 wrap inside HUNT is no lap
    step(1, 0, 4'b0000); expect_all("rst",   0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'b1000); expect_all("acq0",  1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'b0001); expect_all("acq1",  1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'b0010); expect_all("acq2",  1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4'b0100); expect_all("acq3",  1, 2, 1, 0, 0, 0, 0, 0);

    // 2: locked wrap counts a lap
    step(0, 1, 4'b1000); expect_all("lap0",  1, 3, 1, 0, 0, 0, 0, 0);
    step(0, 1, 4'b0001); expect_all("lap1",  1, 0, 1, 0, 0, 1, 1, 0);

    // 3: illegal codes, then relock from scratch
    step(0, 1, 4'b0110); expect_all("ill0",  0, 0, 0, 1, 0, 0, 1, 1);
    step(0, 1, 4'b0000); expect_all("ill1",  0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 4'b0010); expect_all("rl0",   1, 1, 0, 0, 0, 0, 1, 1);
    step(0, 1, 4'b0100); expect_all("rl1",   1, 2, 0, 0, 0, 0, 1, 1);
    step(0, 1, 4'b1000); expect_all("rl2",   1, 3, 0, 0, 0, 0, 1, 1);
    step(0, 1, 4'b0001); expect_all("rl3",   1, 0, 1, 0, 0, 0, 1, 1);

    // 4: wrong step; the offending sample seeds reacquisition
    step(0, 1, 4'b0100); expect_all("seq0",  1, 2, 0, 0, 1, 0, 1, 2);
    step(0, 1, 4'b1000); expect_all("seq1",  1, 3, 0, 0, 0, 0, 1, 2);
    step(0, 1, 4'b0001); expect_all("seq2",  1, 0, 0, 0, 0, 0, 1, 2);
    step(0, 1, 4'b0010); expect_all("seq3",  1, 1, 1, 0, 0, 0, 1, 2);

    // 5: gapped valid, then a repeated code
    step(0, 1, 4'b0100); expect_all("gap0",  1, 2, 1, 0, 0, 0, 1, 2);
    step(0, 0, 4'b1111); expect_all("gap1",  0, 2, 1, 0, 0, 0, 1, 2);
    step(0, 1, 4'b1000); expect_all("gap2",  1, 3, 1, 0, 0, 0, 1, 2);
    step(0, 0, 4'b0000); expect_all("gap3",  0, 3, 1, 0, 0, 0, 1, 2);
    step(0, 1, 4'b0001); expect_all("gap4",  1, 0, 1, 0, 0, 1, 2, 2);
    step(0, 0, 4'b0001); expect_all("gap5",  0, 0, 1, 0, 0, 0, 2, 2);
    step(0, 1, 4'b0010); expect_all("rep0",  1, 1, 1, 0, 0, 0, 2, 2);
    step(0, 1, 4'b0100); expect_all("rep1",  1, 2, 1, 0, 0, 0, 2, 2);
    step(0, 1, 4'b0100); expect_all("rep2",  1, 2, 0, 0, 1, 0, 2, 3);

    // 6: build lap_count to 5, reset beats in_valid, then saturate err_count
    step(0, 1, 4'b1000); step(0, 1, 4'b0001); step(0, 1, 4'b0010);
    chk("relock6", locked, 1'b1);
    step(0, 1, 4'b0100); step(0, 1, 4'b1000); step(0, 1, 4'b0001);
    chk("lc3", lap_count, 8'd3);
    for (int l = 0; l < 2; l++) begin
      step(0, 1, 4'b0010); step(0, 1, 4'b0100); step(0, 1, 4'b1000); step(0, 1, 4'b0001);
    end
    expect_all("lc5", 1, 0, 1, 0, 0, 1, 5, 3);
    step(1, 1, 4'b0010); expect_all("rst2", 0, 0, 0, 0, 0, 0, 0, 0);

    for (int e = 1; e <= 256; e++) begin
      step(0, 1, 4'b0001); step(0, 1, 4'b0010); step(0, 1, 4'b0100); step(0, 1, 4'b1000);
      if (e == 1 || e == 256) chk("sat.locked", locked, 1'b1);
      step(0, 1, 4'b0000);
      chk("sat.err_count", err_count, (e > 255) ? 8'd255 : 8'(e));
      if (e == 1 || e == 255 || e == 256) chk("sat.err_illegal", err_illegal, 1'b1);
    end
    chk("sat.lap_count", lap_count, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
